// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: PC, req/ack instruction-memory port, IF/ID register,
// one-entry hold buffer for words acked under stall, and halt-on-HLT control.
module if_fetch_stage #(
    parameter int                   WORD_SIZE = 16,
    parameter logic [WORD_SIZE-1:0] RESET_PC  = '0
) (
    input  logic                 clk,
    input  logic                 reset_n,
    output logic                 mem_req,
    output logic [WORD_SIZE-1:0] mem_addr,
    input  logic [WORD_SIZE-1:0] mem_rdata,
    input  logic                 mem_ack,
    input  logic                 stall,
    input  logic                 redirect,
    input  logic [WORD_SIZE-1:0] redirect_pc,
    output logic [WORD_SIZE-1:0] ifid_instr,
    output logic [WORD_SIZE-1:0] ifid_pc_next,
    output logic                 ifid_valid,
    output logic                 fetch_halted,
    output logic [WORD_SIZE-1:0] fetch_count
);

    typedef enum logic [1:0] {
        S_RUN    = 2'd0,
        S_HOLD   = 2'd1,
        S_HALTED = 2'd2
    } state_t;

    localparam logic [3:0] OP_RRR = 4'd15;
    localparam logic [5:0] FN_HLT = 6'd29;

    function automatic logic is_hlt(input logic [WORD_SIZE-1:0] w);
        return (w[WORD_SIZE-1 -: 4] == OP_RRR) && (w[5:0] == FN_HLT);
    endfunction

    state_t               r_state, w_state_nxt;
    logic                 r_started;
    logic [WORD_SIZE-1:0] r_pc, w_pc_nxt;
    logic [WORD_SIZE-1:0] r_hold_instr, w_hold_instr_nxt;
    logic [WORD_SIZE-1:0] r_hold_pc_next, w_hold_pc_next_nxt;
    logic                 r_hold_halt, w_hold_halt_nxt;
    logic [WORD_SIZE-1:0] r_ifid_instr, w_ifid_instr_nxt;
    logic [WORD_SIZE-1:0] r_ifid_pc_next, w_ifid_pc_next_nxt;
    logic                 r_ifid_valid, w_ifid_valid_nxt;
    logic                 r_halted, w_halted_nxt;
    logic [WORD_SIZE-1:0] r_count, w_count_nxt;

    logic                 w_mem_req;
    logic                 w_take;
    logic [WORD_SIZE-1:0] w_pc_inc;

    assign mem_req      = w_mem_req;
    assign mem_addr     = r_pc;
    assign ifid_instr   = r_ifid_instr;
    assign ifid_pc_next = r_ifid_pc_next;
    assign ifid_valid   = r_ifid_valid;
    assign fetch_halted = r_halted;
    assign fetch_count  = r_count;

    // Next-state and datapath decode; redirect overrides stall, which overrides normal fetch.
    always_comb begin
        // r_started keeps the request low until the first edge after reset release,
        // so a stale ack arriving right after release cannot be accepted.
        w_mem_req          = r_started && (r_state == S_RUN) && !redirect;
        w_take             = w_mem_req && mem_ack;
        w_pc_inc           = r_pc + WORD_SIZE'(1);
        w_state_nxt        = r_state;
        w_pc_nxt           = r_pc;
        w_hold_instr_nxt   = r_hold_instr;
        w_hold_pc_next_nxt = r_hold_pc_next;
        w_hold_halt_nxt    = r_hold_halt;
        w_ifid_instr_nxt   = r_ifid_instr;
        w_ifid_pc_next_nxt = r_ifid_pc_next;
        w_ifid_valid_nxt   = r_ifid_valid;
        w_halted_nxt       = r_halted;
        w_count_nxt        = r_count;

        if (redirect) begin
            w_pc_nxt           = redirect_pc;
            w_ifid_valid_nxt   = 1'b0;
            w_hold_instr_nxt   = '0;
            w_hold_pc_next_nxt = '0;
            w_hold_halt_nxt    = 1'b0;
            w_state_nxt        = S_RUN;
            w_halted_nxt       = 1'b0;
        end else begin
            case (r_state)
                S_RUN: begin
                    if (w_take) begin
                        w_pc_nxt = w_pc_inc;
                        if (!stall) begin
                            w_ifid_instr_nxt   = mem_rdata;
                            w_ifid_pc_next_nxt = w_pc_inc;
                            w_ifid_valid_nxt   = 1'b1;
                            w_count_nxt        = r_count + WORD_SIZE'(1);
                            if (is_hlt(mem_rdata)) begin
                                w_state_nxt  = S_HALTED;
                                w_halted_nxt = 1'b1;
                            end
                        end else begin
                            // Halt-pending is HOLD with the flag set; the halt takes
                            // effect only once the word actually enters IF/ID.
                            w_hold_instr_nxt   = mem_rdata;
                            w_hold_pc_next_nxt = w_pc_inc;
                            w_hold_halt_nxt    = is_hlt(mem_rdata);
                            w_state_nxt        = S_HOLD;
                        end
                    end else if (!stall) begin
                        w_ifid_valid_nxt = 1'b0;
                    end
                end
                S_HOLD: begin
                    if (!stall) begin
                        w_ifid_instr_nxt   = r_hold_instr;
                        w_ifid_pc_next_nxt = r_hold_pc_next;
                        w_ifid_valid_nxt   = 1'b1;
                        w_count_nxt        = r_count + WORD_SIZE'(1);
                        w_hold_halt_nxt    = 1'b0;
                        w_state_nxt        = r_hold_halt ? S_HALTED : S_RUN;
                        w_halted_nxt       = r_hold_halt;
                    end
                end
                S_HALTED: begin
                    if (!stall) begin
                        w_ifid_valid_nxt = 1'b0;
                    end
                end
                default: begin
                    w_state_nxt = S_RUN;
                end
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // PC, hold buffer, IF/ID register and status counters.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_started      <= 1'b0;
            r_pc           <= RESET_PC;
            r_hold_instr   <= '0;
            r_hold_pc_next <= '0;
            r_hold_halt    <= 1'b0;
            r_ifid_instr   <= '0;
            r_ifid_pc_next <= '0;
            r_ifid_valid   <= 1'b0;
            r_halted       <= 1'b0;
            r_count        <= '0;
        end else begin
            r_started      <= 1'b1;
            r_pc           <= w_pc_nxt;
            r_hold_instr   <= w_hold_instr_nxt;
            r_hold_pc_next <= w_hold_pc_next_nxt;
            r_hold_halt    <= w_hold_halt_nxt;
            r_ifid_instr   <= w_ifid_instr_nxt;
            r_ifid_pc_next <= w_ifid_pc_next_nxt;
            r_ifid_valid   <= w_ifid_valid_nxt;
            r_halted       <= w_halted_nxt;
            r_count        <= w_count_nxt;
        end
    end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage: memory returns 16'h1000+addr, except a HLT at address 8.
module tb_if_fetch_stage;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic [15:0] mem_rdata;
    logic        mem_ack;
    logic        stall;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic [15:0] ifid_instr;
    logic [15:0] ifid_pc_next;
    logic        ifid_valid;
    logic        fetch_halted;
    logic [15:0] fetch_count;

    logic        ack_en;
    logic        force_ack;
    int          n_pass = 0;
    int          n_total = 0;

    always #5 clk = ~clk;

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        if (a == 16'h0008) return 16'hF01D;
        return 16'h1000 + a;
    endfunction

    assign mem_ack   = (mem_req & ack_en) | force_ack;
    assign mem_rdata = mem_ack ? mem_word(mem_addr) : 16'h0000;

    if_fetch_stage #(.WORD_SIZE(16), .RESET_PC(16'h0000)) dut (
        .clk(clk), .reset_n(reset_n),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
        .ifid_instr(ifid_instr), .ifid_pc_next(ifid_pc_next), .ifid_valid(ifid_valid),
        .fetch_halted(fetch_halted), .fetch_count(fetch_count)
    );

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset_n = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = 16'h0000;
        ack_en = 1'b0; force_ack = 1'b0;
        repeat (2) @(negedge clk);
        n_total++; if (mem_req !== 1'b0) $display("FAIL rst_req got=%b exp=0", mem_req); else n_pass++;
        n_total++; if (mem_addr !== 16'h0000) $display("FAIL rst_addr got=%h exp=0000", mem_addr); else n_pass++;
        n_total++; if (ifid_valid !== 1'b0) $display("FAIL rst_valid got=%b exp=0", ifid_valid); else n_pass++;
        n_total++; if (fetch_count !== 16'h0000) $display("FAIL rst_count got=%h exp=0000", fetch_count); else n_pass++;
        reset_n = 1'b1;
        ack_en  = 1'b1;
        #1;
        n_total++; if (mem_req !== 1'b0) $display("FAIL rel_req_before_edge got=%b exp=0", mem_req); else n_pass++;
        tick();
        n_total++; if (mem_req !== 1'b1) $display("FAIL rel_req got=%b exp=1", mem_req); else n_pass++;
        n_total++; if (ifid_valid !== 1'b0) $display("FAIL rel_valid got=%b exp=0", ifid_valid); else n_pass++;
    endtask

    task automatic test_zero_wait();
        logic [15:0] exp_i;
        for (int i = 0; i < 3; i++) begin
            tick();
            exp_i = 16'h1000 + 16'(i);
            n_total++; if (ifid_instr !== exp_i) $display("FAIL zw_instr%0d got=%h exp=%h", i, ifid_instr, exp_i); else n_pass++;
            n_total++; if (ifid_pc_next !== 16'(i + 1)) $display("FAIL zw_pcn%0d got=%h exp=%h", i, ifid_pc_next, 16'(i + 1)); else n_pass++;
            n_total++; if (ifid_valid !== 1'b1) $display("FAIL zw_valid%0d got=%b exp=1", i, ifid_valid); else n_pass++;
        end
        n_total++; if (fetch_count !== 16'd3) $display("FAIL zw_count got=%h exp=0003", fetch_count); else n_pass++;
        ack_en = 1'b0;
    endtask

    task automatic test_wait_states();
        logic [15:0] a;
        for (int k = 0; k < 2; k++) begin
            a = 16'd3 + 16'(k);
            for (int w = 0; w < 2; w++) begin
                tick();
                n_total++; if (ifid_valid !== 1'b0) $display("FAIL ws_bubble%0d_%0d got=%b exp=0", k, w, ifid_valid); else n_pass++;
                n_total++; if (mem_addr !== a) $display("FAIL ws_addr%0d_%0d got=%h exp=%h", k, w, mem_addr, a); else n_pass++;
                n_total++; if (mem_req !== 1'b1) $display("FAIL ws_req%0d_%0d got=%b exp=1", k, w, mem_req); else n_pass++;
            end
            ack_en = 1'b1;
            tick();
            ack_en = 1'b0;
            n_total++; if (ifid_instr !== 16'h1000 + a) $display("FAIL ws_instr%0d got=%h exp=%h", k, ifid_instr, 16'h1000 + a); else n_pass++;
            n_total++; if (ifid_pc_next !== a + 16'd1) $display("FAIL ws_pcn%0d got=%h exp=%h", k, ifid_pc_next, a + 16'd1); else n_pass++;
        end
        n_total++; if (fetch_count !== 16'd5) $display("FAIL ws_count got=%h exp=0005", fetch_count); else n_pass++;
    endtask

    task automatic test_stall_hold();
        ack_en = 1'b1;
        stall  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_total++; if (mem_req !== 1'b0) $display("FAIL st_req%0d got=%b exp=0", i, mem_req); else n_pass++;
            n_total++; if (ifid_instr !== 16'h1004) $display("FAIL st_instr%0d got=%h exp=1004", i, ifid_instr); else n_pass++;
            n_total++; if (ifid_pc_next !== 16'h0005) $display("FAIL st_pcn%0d got=%h exp=0005", i, ifid_pc_next); else n_pass++;
            n_total++; if (ifid_valid !== 1'b1) $display("FAIL st_valid%0d got=%b exp=1", i, ifid_valid); else n_pass++;
            n_total++; if (fetch_count !== 16'd5) $display("FAIL st_count%0d got=%h exp=0005", i, fetch_count); else n_pass++;
        end
        stall = 1'b0;
        tick();
        n_total++; if (ifid_instr !== 16'h1005) $display("FAIL st_rel_instr got=%h exp=1005", ifid_instr); else n_pass++;
        n_total++; if (ifid_pc_next !== 16'h0006) $display("FAIL st_rel_pcn got=%h exp=0006", ifid_pc_next); else n_pass++;
        n_total++; if (fetch_count !== 16'd6) $display("FAIL st_rel_count got=%h exp=0006", fetch_count); else n_pass++;
        n_total++; if (mem_req !== 1'b1) $display("FAIL st_rel_req got=%b exp=1", mem_req); else n_pass++;
        n_total++; if (mem_addr !== 16'h0006) $display("FAIL st_rel_addr got=%h exp=0006", mem_addr); else n_pass++;
    endtask

    task automatic test_halt();
        repeat (3) tick();
        n_total++; if (ifid_instr !== 16'hF01D) $display("FAIL h_instr got=%h exp=F01D", ifid_instr); else n_pass++;
        n_total++; if (ifid_pc_next !== 16'h0009) $display("FAIL h_pcn got=%h exp=0009", ifid_pc_next); else n_pass++;
        n_total++; if (fetch_halted !== 1'b1) $display("FAIL h_halted got=%b exp=1", fetch_halted); else n_pass++;
        n_total++; if (mem_req !== 1'b0) $display("FAIL h_req got=%b exp=0", mem_req); else n_pass++;
        n_total++; if (fetch_count !== 16'd9) $display("FAIL h_count got=%h exp=0009", fetch_count); else n_pass++;
        for (int i = 0; i < 2; i++) begin
            tick();
            n_total++; if (ifid_valid !== 1'b0) $display("FAIL h_bubble%0d got=%b exp=0", i, ifid_valid); else n_pass++;
            n_total++; if (mem_req !== 1'b0) $display("FAIL h_req%0d got=%b exp=0", i, mem_req); else n_pass++;
            n_total++; if (mem_addr !== 16'h0009) $display("FAIL h_addr%0d got=%h exp=0009", i, mem_addr); else n_pass++;
            n_total++; if (fetch_count !== 16'd9) $display("FAIL h_count%0d got=%h exp=0009", i, fetch_count); else n_pass++;
        end
    endtask

    task automatic test_redirect();
        redirect    = 1'b1;
        redirect_pc = 16'h0020;
        force_ack   = 1'b1;
        #1;
        n_total++; if (mem_req !== 1'b0) $display("FAIL rd_req got=%b exp=0", mem_req); else n_pass++;
        @(posedge clk);
        @(negedge clk);
        redirect  = 1'b0;
        force_ack = 1'b0;
        #1;
        n_total++; if (fetch_halted !== 1'b0) $display("FAIL rd_halted got=%b exp=0", fetch_halted); else n_pass++;
        n_total++; if (ifid_valid !== 1'b0) $display("FAIL rd_valid got=%b exp=0", ifid_valid); else n_pass++;
        n_total++; if (mem_addr !== 16'h0020) $display("FAIL rd_addr got=%h exp=0020", mem_addr); else n_pass++;
        n_total++; if (mem_req !== 1'b1) $display("FAIL rd_req_next got=%b exp=1", mem_req); else n_pass++;
        n_total++; if (fetch_count !== 16'd9) $display("FAIL rd_ack_dropped got=%h exp=0009", fetch_count); else n_pass++;
        tick();
        n_total++; if (ifid_instr !== 16'h1020) $display("FAIL rd_instr got=%h exp=1020", ifid_instr); else n_pass++;
        n_total++; if (ifid_pc_next !== 16'h0021) $display("FAIL rd_pcn got=%h exp=0021", ifid_pc_next); else n_pass++;
        n_total++; if (fetch_count !== 16'd10) $display("FAIL rd_count got=%h exp=000a", fetch_count); else n_pass++;
    endtask

    task automatic test_wrap_and_reset();
        redirect    = 1'b1;
        redirect_pc = 16'hFFFF;
        ack_en      = 1'b0;
        @(posedge clk);
        @(negedge clk);
        redirect = 1'b0;
        ack_en   = 1'b1;
        #1;
        n_total++; if (mem_addr !== 16'hFFFF) $display("FAIL wr_addr got=%h exp=FFFF", mem_addr); else n_pass++;
        tick();
        ack_en = 1'b0;
        n_total++; if (ifid_instr !== 16'h0FFF) $display("FAIL wr_instr got=%h exp=0FFF", ifid_instr); else n_pass++;
        n_total++; if (ifid_pc_next !== 16'h0000) $display("FAIL wr_pcn got=%h exp=0000", ifid_pc_next); else n_pass++;
        n_total++; if (mem_addr !== 16'h0000) $display("FAIL wr_next_addr got=%h exp=0000", mem_addr); else n_pass++;
        n_total++; if (fetch_count !== 16'd11) $display("FAIL wr_count got=%h exp=000b", fetch_count); else n_pass++;
        // request at pc 0 is outstanding; abandon it with an asynchronous reset
        #1 reset_n = 1'b0;
        #1;
        n_total++; if (mem_req !== 1'b0) $display("FAIL ar_req got=%b exp=0", mem_req); else n_pass++;
        n_total++; if (ifid_instr !== 16'h0000) $display("FAIL ar_instr got=%h exp=0000", ifid_instr); else n_pass++;
        n_total++; if (ifid_pc_next !== 16'h0000) $display("FAIL ar_pcn got=%h exp=0000", ifid_pc_next); else n_pass++;
        n_total++; if (ifid_valid !== 1'b0) $display("FAIL ar_valid got=%b exp=0", ifid_valid); else n_pass++;
        n_total++; if (fetch_count !== 16'h0000) $display("FAIL ar_count got=%h exp=0000", fetch_count); else n_pass++;
        @(negedge clk);
        reset_n   = 1'b1;
        force_ack = 1'b1;
        #1;
        n_total++; if (mem_req !== 1'b0) $display("FAIL ar_rel_req got=%b exp=0", mem_req); else n_pass++;
        @(posedge clk);
        @(negedge clk);
        force_ack = 1'b0;
        #1;
        n_total++; if (ifid_valid !== 1'b0) $display("FAIL ar_late_valid got=%b exp=0", ifid_valid); else n_pass++;
        n_total++; if (fetch_count !== 16'h0000) $display("FAIL ar_late_count got=%h exp=0000", fetch_count); else n_pass++;
        n_total++; if (mem_req !== 1'b1) $display("FAIL ar_new_req got=%b exp=1", mem_req); else n_pass++;
        n_total++; if (mem_addr !== 16'h0000) $display("FAIL ar_new_addr got=%h exp=0000", mem_addr); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_zero_wait();
        test_wait_states();
        test_stall_hold();
        test_halt();
        test_redirect();
        test_wrap_and_reset();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
